// File: rtl/hires_pkg.sv
// Shared types and constants for the hi-res character fetch path.
// Holds the fetch FSM state encoding, the attribute bit positions, the
// fetch-window bounds and the holding-register payload.
package hires_pkg;

  localparam int unsigned VC_W     = 11;
  localparam int unsigned RC_W     = 3;
  localparam int unsigned BASE_W   = 5;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned COL_W    = 4;
  localparam int unsigned CYC_W    = 7;

  localparam int unsigned WIN_FIRST = 15;
  localparam int unsigned WIN_LAST  = 54;

  localparam int unsigned ATTR_BLINK     = 4;
  localparam int unsigned ATTR_UNDERLINE = 5;
  localparam int unsigned ATTR_REVERSE   = 6;
  localparam int unsigned ATTR_ALTCS     = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CODE  = 3'd1,
    ST_RD_ATTR  = 3'd2,
    ST_RD_GLYPH = 3'd3,
    ST_DONE     = 3'd4
  } fetch_state_e;

  // One slot's fetched character, kept until the next slot start
  typedef struct packed {
    logic [DATA_W-1:0] glyph;
    logic [DATA_W-1:0] attr;
    logic [RC_W-1:0]   rc;
  } hold_t;

  // True for PHI cycles that carry a hi-res fetch
  function automatic logic in_window(input logic [CYC_W-1:0] cyc);
    return (cyc >= CYC_W'(WIN_FIRST)) && (cyc <= CYC_W'(WIN_LAST));
  endfunction

endpackage

// File: rtl/hires_pixel_shifter.sv
// Pixel serializer for the hi-res character path.
// On load it takes one held character, applies underline/blink/reverse and
// then emits 8 pixels, MSB first, one every other tick.
// Ports:
//   clk_dot4x, rst_n        clock / async active-low reset
//   load                    slot start with something to show
//   show_glyph              1: use hold, 0: emit a blank (all-background) row
//   hold                    glyph, attribute and glyph row
//   blink_phase, bg_color   blink clock level and background colour
//   pixel_valid, pixel_color  registered pixel strobe and colour
module hires_pixel_shifter
  import hires_pkg::*;
(
  input  logic             clk_dot4x,
  input  logic             rst_n,
  input  logic             load,
  input  logic             show_glyph,
  input  hold_t            hold,
  input  logic             blink_phase,
  input  logic [COL_W-1:0] bg_color,
  output logic             pixel_valid,
  output logic [COL_W-1:0] pixel_color
);

  logic [DATA_W-1:0] pix_c;
  logic [COL_W-1:0]  fg_c;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [COL_W-1:0]  fg_q, fg_d;
  logic [2:0]        left_q, left_d;
  logic              gap_q, gap_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [COL_W-1:0]  pixel_color_q, pixel_color_d;

  // Attribute effects; reverse applies to the result of underline/blink
  always_comb begin : attr_apply
    pix_c = hold.glyph;
    if (hold.attr[ATTR_UNDERLINE] && (hold.rc == RC_W'(7))) pix_c = 8'hFF;
    if (hold.attr[ATTR_BLINK] && blink_phase)               pix_c = 8'h00;
    if (hold.attr[ATTR_REVERSE])                            pix_c = ~pix_c;
    if (!show_glyph)                                        pix_c = 8'h00;
    fg_c = show_glyph ? hold.attr[COL_W-1:0] : COL_W'(0);
  end

  // First pixel on the load tick, then one pixel after each idle gap tick
  always_comb begin : shift_next
    shift_d       = shift_q;
    fg_d          = fg_q;
    left_d        = left_q;
    gap_d         = gap_q;
    pixel_valid_d = 1'b0;
    pixel_color_d = COL_W'(0);
    if (load) begin
      shift_d       = {pix_c[6:0], 1'b0};
      fg_d          = fg_c;
      left_d        = 3'd7;
      gap_d         = 1'b1;
      pixel_valid_d = 1'b1;
      pixel_color_d = pix_c[7] ? fg_c : bg_color;
    end else if (gap_q) begin
      gap_d = 1'b0;
    end else if (left_q != 3'd0) begin
      shift_d       = {shift_q[6:0], 1'b0};
      left_d        = left_q - 3'd1;
      gap_d         = 1'b1;
      pixel_valid_d = 1'b1;
      pixel_color_d = shift_q[7] ? fg_q : bg_color;
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin : shift_regs
    if (!rst_n) begin
      shift_q       <= '0;
      fg_q          <= '0;
      left_q        <= '0;
      gap_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_color_q <= '0;
    end else begin
      shift_q       <= shift_d;
      fg_q          <= fg_d;
      left_q        <= left_d;
      gap_q         <= gap_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_color_q <= pixel_color_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_color = pixel_color_q;

endmodule

// File: rtl/hires_char_fetch.sv
// Hi-res character fetch: per 80-column half-PHI slot, reads character code,
// attribute and glyph row over a req/ack port, holds the result for one slot
// and hands it to the pixel shifter at the next slot start.
// Ports:
//   clk_dot4x, rst_n            clock / async active-low reset
//   clk_phi, phi_phase_start_1  PHI level and slot-start strobe
//   cycle_num, hires_vc/rc      PHI cycle, matrix index and glyph row
//   matrix/color/char_base      address bits [15:11] for the three reads
//   bg_color, blink_phase       background colour, blink clock
//   mem_req/addr/ack/data       video RAM read port
//   pixel_valid, pixel_color    serialized pixels
//   fetch_overrun, overrun_clr  sticky late-fetch flag and its clear
module hires_char_fetch
  import hires_pkg::*;
#(
  parameter int unsigned SLOT_TICKS   = 16,
  parameter int unsigned ACK_DEADLINE = 12
) (
  input  logic              clk_dot4x,
  input  logic              rst_n,
  input  logic              clk_phi,
  input  logic              phi_phase_start_1,
  input  logic [CYC_W-1:0]  cycle_num,
  input  logic [VC_W-1:0]   hires_vc,
  input  logic [RC_W-1:0]   hires_rc,
  input  logic [BASE_W-1:0] matrix_base,
  input  logic [BASE_W-1:0] color_base,
  input  logic [BASE_W-1:0] char_base,
  input  logic [COL_W-1:0]  bg_color,
  input  logic              blink_phase,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pixel_valid,
  output logic [COL_W-1:0]  pixel_color,
  output logic              fetch_overrun,
  input  logic              overrun_clr
);

  localparam int unsigned TICK_W = $clog2(SLOT_TICKS);

  fetch_state_e state_q, state_d;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              in_win_q, in_win_d;
  logic              start_q, start_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic [DATA_W-1:0] attr_q, attr_d;
  logic [DATA_W-1:0] glyph_q, glyph_d;
  hold_t             hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              overrun_q, overrun_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic rd_c, late_c, take_c, abort_c, load_c;

  // Both PHI levels fetch, so the PHI level itself carries no information
  logic unused_phi;
  assign unused_phi = clk_phi;

  // Ack is accepted up to ACK_DEADLINE; past it any pending read is abandoned
  assign rd_c    = (state_q == ST_RD_CODE) || (state_q == ST_RD_ATTR) ||
                   (state_q == ST_RD_GLYPH);
  assign late_c  = tick_q > TICK_W'(ACK_DEADLINE);
  assign take_c  = rd_c && !late_c && mem_ack;
  assign abort_c = rd_c && late_c;

  // FSM state register
  always_ff @(posedge clk_dot4x or negedge rst_n) begin : fsm_reg
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; leaves IDLE on the tick after the slot start registers
  // vc/rc, so mem_req first appears at slot tick 1
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_q) state_d = ST_RD_CODE;
      ST_RD_CODE:  if (late_c) state_d = ST_IDLE;
                   else if (mem_ack) state_d = ST_RD_ATTR;
      ST_RD_ATTR:  if (late_c) state_d = ST_IDLE;
                   else if (mem_ack) state_d = ST_RD_GLYPH;
      ST_RD_GLYPH: if (late_c) state_d = ST_IDLE;
                   else if (mem_ack) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, registered from the next state; address moves only on a
  // transition. The glyph address uses the attribute arriving this tick.
  always_comb begin : fsm_out
    mem_req_d  = (state_d == ST_RD_CODE) || (state_d == ST_RD_ATTR) ||
                 (state_d == ST_RD_GLYPH);
    mem_addr_d = mem_addr_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_RD_CODE:  mem_addr_d = {matrix_base, vc_q};
        ST_RD_ATTR:  mem_addr_d = {color_base, vc_q};
        ST_RD_GLYPH: mem_addr_d = {char_base[4:1],
                                   mem_data[ATTR_ALTCS] ^ char_base[0],
                                   code_q, rc_q};
        default:     mem_addr_d = mem_addr_q;
      endcase
    end
  end

  // Slot timing, read latches, holding register and overrun flag
  always_comb begin : data_next
    tick_d       = tick_q;
    in_win_d     = in_win_q;
    start_d      = 1'b0;
    vc_d         = vc_q;
    rc_d         = rc_q;
    code_d       = code_q;
    attr_d       = attr_q;
    glyph_d      = glyph_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q;

    if (phi_phase_start_1) begin
      tick_d       = '0;
      in_win_d     = in_window(cycle_num);
      start_d      = in_window(cycle_num);
      vc_d         = hires_vc;
      rc_d         = hires_rc;
      hold_valid_d = 1'b0;
    end else if (tick_q != TICK_W'(SLOT_TICKS - 1)) begin
      tick_d = tick_q + TICK_W'(1);
    end

    if (take_c && (state_q == ST_RD_CODE))  code_d  = mem_data;
    if (take_c && (state_q == ST_RD_ATTR))  attr_d  = mem_data;
    if (take_c && (state_q == ST_RD_GLYPH)) glyph_d = mem_data;

    if (state_q == ST_DONE) begin
      hold_d       = '{glyph: glyph_q, attr: attr_q, rc: rc_q};
      hold_valid_d = 1'b1;
    end
    if (abort_c) hold_valid_d = 1'b0;

    if (overrun_clr)  overrun_d = 1'b0;
    else if (abort_c) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin : data_regs
    if (!rst_n) begin
      tick_q       <= TICK_W'(SLOT_TICKS - 1);
      in_win_q     <= 1'b0;
      start_q      <= 1'b0;
      vc_q         <= '0;
      rc_q         <= '0;
      code_q       <= '0;
      attr_q       <= '0;
      glyph_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      tick_q       <= tick_d;
      in_win_q     <= in_win_d;
      start_q      <= start_d;
      vc_q         <= vc_d;
      rc_q         <= rc_d;
      code_q       <= code_d;
      attr_q       <= attr_d;
      glyph_q      <= glyph_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overrun_q    <= overrun_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // An empty hold still produces a background row when the slot just ending
  // was a fetch slot (its fetch failed); outside the window nothing is shown
  assign load_c = phi_phase_start_1 && (hold_valid_q || in_win_q);

  hires_pixel_shifter u_shifter (
    .clk_dot4x   (clk_dot4x),
    .rst_n       (rst_n),
    .load        (load_c),
    .show_glyph  (hold_valid_q),
    .hold        (hold_q),
    .blink_phase (blink_phase),
    .bg_color    (bg_color),
    .pixel_valid (pixel_valid),
    .pixel_color (pixel_color)
  );

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign fetch_overrun = overrun_q;

endmodule
